ifu_fetch: RTL and testbench



---
 rtl/npc_pkg.sv | 34 +++
 rtl/ifu_fetch.sv | 160 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// ---------------------------------------------------------------------------
// npc_pkg -- shared definitions for the NPC core front end.
//
// Contents:
//   INST_W          instruction / address width
//   RESET_PC_DEF    default reset PC
//   NPC_ABORT       halt code passed to set_npc_state on a fatal fault
//   fetch_state_e   ifu_fetch FSM state encoding
//   is_misaligned() true when a PC is not 4-byte aligned
// ---------------------------------------------------------------------------
package npc_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] RESET_PC_DEF = 32'h8000_0000;

    // Halt codes understood by the simulation environment's set_npc_state.
    localparam int unsigned NPC_RUNNING = 0;
    localparam int unsigned NPC_STOP    = 1;
    localparam int unsigned NPC_ABORT   = 2;

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,  // request on the memory port
        S_WAIT = 3'd1,  // request accepted, waiting for read data
        S_HOLD = 3'd2,  // instruction presented to decode
        S_NPC  = 3'd3,  // waiting for commit to return the next PC
        S_ERR  = 3'd4   // sticky fault, only reset leaves
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [INST_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- single-issue instruction fetch unit for the multi-cycle core.
//
// Holds the PC, issues one 32-bit read per instruction, hands {inst, pc} to
// decode, then waits for commit to return the next PC before fetching again.
// Exactly one instruction is in flight at any time.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_req_*         request channel (valid/ready), addr = pc
//   mem_resp_*        response channel (valid only, no backpressure);
//                     err is an access fault qualified by valid
//   inst, pc          instruction and its PC to decode
//   IFU_valid         inst/pc valid; IDU_ready completes the transfer
//   npc_valid, npc    next PC from commit, honoured only after the transfer
//   fetch_err         sticky fault flag (memory fault, timeout, misaligned npc)
//
// All outputs come straight from registers or from the state register, so
// there is no combinational input-to-output path.
// ---------------------------------------------------------------------------
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned       TIMEOUT  = 255,  // >= 1
    parameter int unsigned       CNT_W    = 8     // 2**CNT_W > TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [INST_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [INST_W-1:0] mem_resp_data,
    input  logic              mem_resp_err,

    output logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] pc,
    output logic              IFU_valid,
    input  logic              IDU_ready,

    input  logic              npc_valid,
    input  logic [INST_W-1:0] npc,

    output logic              fetch_err
);

    // Last wait cycle in which a response is still accepted; the counter
    // starts at 0 on the first wait cycle, so TIMEOUT wait cycles in total.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e      state_q, state_d;
    logic [INST_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              ifu_valid_q, ifu_valid_d;
    logic              req_valid_q, req_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        ifu_valid_d = ifu_valid_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            S_REQ: begin
                // Response traffic here is ignored; only an accepted
                // request (which needs our registered valid) moves us on.
                if (req_valid_q && mem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end

            S_WAIT: begin
                if (mem_resp_valid) begin
                    if (mem_resp_err) begin
                        state_d = S_ERR;
                    end else begin
                        inst_d      = mem_resp_data;
                        ifu_valid_d = 1'b1;
                        state_d     = S_HOLD;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (ifu_valid_q && IDU_ready) begin
                    ifu_valid_d = 1'b0;
                    state_d     = S_NPC;
                end
            end

            S_NPC: begin
                // The misaligned target is still latched so the faulting
                // PC is visible on pc for debug.
                if (npc_valid) begin
                    pc_d    = npc;
                    state_d = is_misaligned(npc) ? S_ERR : S_REQ;
                end
            end

            S_ERR: begin
                ifu_valid_d = 1'b0;
            end

            default: begin
                // Unused encodings fall into the fault state.
                state_d     = S_ERR;
                ifu_valid_d = 1'b0;
            end
        endcase

        // Request valid is registered and looks ahead at the next state,
        // so it is high for exactly the cycles spent in S_REQ after the
        // first post-reset cycle, and never high while rst is asserted.
        req_valid_d = (state_d == S_REQ);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            ifu_valid_q <= 1'b0;
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            ifu_valid_q <= ifu_valid_d;
            req_valid_q <= req_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = pc_q;
    assign inst          = inst_q;
    assign pc            = pc_q;
    assign IFU_valid     = ifu_valid_q;
    assign fetch_err     = (state_q == S_ERR);

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam int          TO = 4;
    localparam logic [31:0] E  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid, mem_resp_err;
    logic [31:0] mem_resp_data;
    logic [31:0] inst, pc;
    logic        IFU_valid, IDU_ready;
    logic        npc_valid;
    logic [31:0] npc;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_fetch #(.RESET_PC(E), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_err(mem_resp_err),
        .inst(inst), .pc(pc), .IFU_valid(IFU_valid), .IDU_ready(IDU_ready),
        .npc_valid(npc_valid), .npc(npc),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        mem_resp_data  = '0;
        IDU_ready      = 1'b0;
        npc_valid      = 1'b0;
        npc            = '0;
    endtask

    // Leaves rst low for the first post-reset cycle (before its negedge).
    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- table-driven directed vectors ----------------
    typedef struct {
        logic        rst, rdy, rv, re;
        logic [31:0] rd;
        logic        idr, nv;
        logic [31:0] np;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst, e_pc;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, rdy, rv, re, input logic [31:0] rd,
                       input logic idr, nv, input logic [31:0] np,
                       input logic erv, input logic [31:0] eaddr, input logic eiv,
                       input logic [31:0] einst, epc, input logic eerr);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rv = rv; v.re = re; v.rd = rd;
        v.idr = idr; v.nv = nv; v.np = np;
        v.e_rv = erv; v.e_addr = eaddr; v.e_iv = eiv;
        v.e_inst = einst; v.e_pc = epc; v.e_err = eerr;
        tbl.push_back(v);
    endtask

    task automatic run_table();
        logic [31:0] i0, i1, a4;
        i0 = 32'h0000_0513;
        i1 = 32'h0010_0093;
        a4 = 32'h8000_0004;
        //   rst rdy rv re rd  idr nv np            rv addr iv inst pc err
        add(1, 0, 0, 0, 0,  0, 0, 0,              0, E,  0, 0,  E,  0); // reset values
        add(0, 1, 0, 0, 0,  0, 0, 0,              0, E,  0, 0,  E,  0); // post-reset bubble
        add(0, 1, 0, 0, 0,  0, 0, 0,              1, E,  0, 0,  E,  0); // cycle 1: accept
        add(0, 0, 1, 0, i0, 0, 0, 0,              0, E,  0, 0,  E,  0); // response
        add(0, 0, 0, 0, 0,  0, 1, 32'h1234_0000,  0, E,  1, i0, E,  0); // cycle 3, stray npc
        for (int k = 0; k < 4; k++)
            add(0, 0, 0, 0, 0, 0, 0, 0,           0, E,  1, i0, E,  0); // held
        add(0, 0, 0, 0, 0,  1, 0, 0,              0, E,  1, i0, E,  0); // transfer
        add(0, 0, 0, 0, 0,  0, 0, 0,              0, E,  0, i0, E,  0); // valid drops
        add(0, 0, 0, 0, 0,  0, 1, a4,             0, E,  0, i0, E,  0); // npc
        for (int k = 0; k < 3; k++)
            add(0, 0, 0, 0, 0, 0, 0, 0,           1, a4, 0, i0, a4, 0); // stalled req
        add(0, 1, 0, 0, 0,  0, 0, 0,              1, a4, 0, i0, a4, 0); // accept
        add(0, 1, 0, 0, 0,  0, 0, 0,              0, a4, 0, i0, a4, 0); // no 2nd request
        add(0, 0, 1, 0, i1, 0, 0, 0,              0, a4, 0, i0, a4, 0); // response
        add(0, 0, 0, 0, 0,  0, 0, 0,              0, a4, 1, i1, a4, 0); // presented
        add(1, 0, 0, 0, 0,  1, 0, 0,              0, a4, 1, i1, a4, 0); // rst beats transfer
        add(0, 0, 0, 0, 0,  0, 0, 0,              0, E,  0, 0,  E,  0); // reset values
        add(0, 0, 0, 0, 0,  0, 0, 0,              1, E,  0, 0,  E,  0); // refetch RESET_PC

        rst = 1'b1;
        idle();
        step();
        step();
        foreach (tbl[i]) begin
            rst = tbl[i].rst; mem_req_ready = tbl[i].rdy;
            mem_resp_valid = tbl[i].rv; mem_resp_err = tbl[i].re; mem_resp_data = tbl[i].rd;
            IDU_ready = tbl[i].idr; npc_valid = tbl[i].nv; npc = tbl[i].np;
            neg();
            chk($sformatf("tbl%0d req_valid", i), 32'(mem_req_valid), 32'(tbl[i].e_rv));
            chk($sformatf("tbl%0d req_addr", i),  mem_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d IFU_valid", i), 32'(IFU_valid), 32'(tbl[i].e_iv));
            chk($sformatf("tbl%0d inst", i),      inst, tbl[i].e_inst);
            chk($sformatf("tbl%0d pc", i),        pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d fetch_err", i), 32'(fetch_err), 32'(tbl[i].e_err));
            step();
        end
        idle();
    endtask

    // ---------------- hand-written corner sequences ----------------
    task automatic accept_first();
        do_reset();
        step();                     // bubble cycle
        mem_req_ready = 1'b1;
        step();                     // accepted
        mem_req_ready = 1'b0;
    endtask

    task automatic seq_resp_err();
        accept_first();
        mem_resp_valid = 1'b1; mem_resp_err = 1'b1; mem_resp_data = 32'hdead_beef;
        step();
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_req_ready = 1'b1; mem_resp_valid = 1'b1; IDU_ready = 1'b1;
            neg();
            chk("err fetch_err", 32'(fetch_err), 1);
            chk("err req_valid", 32'(mem_req_valid), 0);
            chk("err IFU_valid", 32'(IFU_valid), 0);
            step();
        end
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        neg();
        chk("err cleared", 32'(fetch_err), 0);
        step();
        neg();
        chk("err refetch valid", 32'(mem_req_valid), 1);
        chk("err refetch addr", mem_req_addr, E);
        step();
    endtask

    task automatic seq_timeout();
        accept_first();
        for (int k = 0; k < TO; k++) begin
            neg();
            chk($sformatf("to wait%0d fetch_err", k), 32'(fetch_err), 0);
            step();
        end
        neg();
        chk("timeout fetch_err", 32'(fetch_err), 1);
        chk("timeout IFU_valid", 32'(IFU_valid), 0);
        step();
    endtask

    task automatic seq_late_resp();
        accept_first();
        for (int k = 0; k < TO - 1; k++) step();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0073;
        step();
        mem_resp_valid = 1'b0;
        neg();
        chk("late fetch_err", 32'(fetch_err), 0);
        chk("late IFU_valid", 32'(IFU_valid), 1);
        chk("late inst", inst, 32'h0000_0073);
        step();
    endtask

    task automatic seq_misaligned();
        accept_first();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h0000_0013;
        step();
        mem_resp_valid = 1'b0; IDU_ready = 1'b1;
        step();
        IDU_ready = 1'b0; npc_valid = 1'b1; npc = 32'h8000_0002;
        step();
        npc_valid = 1'b0;
        neg();
        chk("mis fetch_err", 32'(fetch_err), 1);
        chk("mis pc", pc, 32'h8000_0002);
        chk("mis req_valid", 32'(mem_req_valid), 0);
        step();
    endtask

    task automatic seq_rst_wait();
        accept_first();
        rst = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_2222;
        step();
        rst = 1'b0; mem_resp_valid = 1'b0;
        neg();
        chk("rstw IFU_valid", 32'(IFU_valid), 0);
        chk("rstw pc", pc, E);
        chk("rstw inst", inst, 0);
        chk("rstw req_valid", 32'(mem_req_valid), 0);
        step();
        neg();
        chk("rstw refetch", 32'(mem_req_valid), 1);
        step();
    endtask

    // ---------------- randomized protocol run ----------------
    // Expectations come from the protocol rules: the request address is the
    // PC most recently handed over by commit, the presented word is the one
    // the memory returned, and faults/timeouts end the run in a sticky error.
    task automatic run_random(input int n_inst);
        logic [31:0] epc, data, nxt;
        int          w, nwait;
        logic        bad;
        do_reset();
        neg();
        chk("rnd bubble", 32'(mem_req_valid), 0);
        step();
        epc = E;
        for (int n = 0; n < n_inst; n++) begin
            for (int s = $urandom_range(0, 3); s > 0; s--) begin
                mem_resp_valid = 1'($urandom); mem_resp_err = 1'($urandom);
                neg();
                chk("rnd stall valid", 32'(mem_req_valid), 1);
                chk("rnd stall addr", mem_req_addr, epc);
                step();
            end
            mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
            mem_req_ready = 1'b1;
            neg();
            chk("rnd accept valid", 32'(mem_req_valid), 1);
            chk("rnd accept addr", mem_req_addr, epc);
            step();
            mem_req_ready = 1'b0;

            w = $urandom_range(0, TO + 1);
            nwait = (w < TO) ? w : TO;
            for (int k = 0; k < nwait; k++) begin
                neg();
                chk("rnd wait req", 32'(mem_req_valid), 0);
                chk("rnd wait err", 32'(fetch_err), 0);
                step();
            end
            if (w >= TO) begin
                neg();
                chk("rnd timeout", 32'(fetch_err), 1);
                return;
            end
            bad = ($urandom_range(0, 7) == 0);
            data = $urandom;
            mem_resp_valid = 1'b1; mem_resp_err = bad; mem_resp_data = data;
            step();
            mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
            if (bad) begin
                neg();
                chk("rnd resp err", 32'(fetch_err), 1);
                chk("rnd resp err iv", 32'(IFU_valid), 0);
                return;
            end

            for (int h = $urandom_range(0, 3); h > 0; h--) begin
                npc_valid = 1'($urandom); npc = $urandom;
                neg();
                chk("rnd hold iv", 32'(IFU_valid), 1);
                chk("rnd hold inst", inst, data);
                chk("rnd hold pc", pc, epc);
                step();
            end
            npc_valid = 1'b0;
            IDU_ready = 1'b1;
            neg();
            chk("rnd xfer iv", 32'(IFU_valid), 1);
            chk("rnd xfer inst", inst, data);
            step();
            IDU_ready = 1'b0;

            for (int d = $urandom_range(0, 2); d > 0; d--) begin
                neg();
                chk("rnd npc iv", 32'(IFU_valid), 0);
                chk("rnd npc req", 32'(mem_req_valid), 0);
                step();
            end
            nxt = $urandom;
            nxt[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            npc_valid = 1'b1; npc = nxt;
            step();
            npc_valid = 1'b0;
            if (nxt[1:0] != 2'b00) begin
                neg();
                chk("rnd misaligned", 32'(fetch_err), 1);
                return;
            end
            epc = nxt;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        run_table();
        seq_resp_err();
        seq_timeout();
        seq_late_resp();
        seq_misaligned();
        seq_rst_wait();
        for (int r = 0; r < 30; r++) run_random(8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
